// File: rtl/bist_pkg.sv
// Shared types and sizes for the 256x4 SRAM BIST: FSM state encoding and the
// compare entry carried through the read-latency delay line.
package bist_pkg;

   localparam int unsigned BIST_ADDR_W = 8;
   localparam int unsigned BIST_DATA_W = 4;

   typedef enum logic [1:0] {
      StIdle,
      StRun,
      StDrain,
      StDone
   } bist_state_e;

   typedef struct packed {
      logic                   valid;
      logic [BIST_ADDR_W-1:0] addr;
      logic [BIST_DATA_W-1:0] exp;
   } cmp_entry_t;

endpackage

// File: rtl/bist_delay_line.sv
// RD_LAT-deep shift register of compare entries; flush clears every stage so
// no stale strobe can retire after a restart or abort.
module bist_delay_line
   import bist_pkg::*;
#(
   parameter int unsigned RD_LAT  = 1,
   parameter type         entry_t = cmp_entry_t
) (
   input  logic   clk,
   input  logic   flush,
   input  entry_t d_in,
   output entry_t d_out
);

   entry_t line_q [RD_LAT];

   always_ff @(posedge clk) begin
      if (flush) begin
         for (int i = 0; i < int'(RD_LAT); i++) begin
            line_q[i] <= '0;
         end
      end else begin
         line_q[0] <= d_in;
         for (int i = 1; i < int'(RD_LAT); i++) begin
            line_q[i] <= line_q[i-1];
         end
      end
   end

   assign d_out = line_q[RD_LAT-1];

endmodule

// File: rtl/bist_resp_cmp.sv
// BIST response comparator: aligns generator strobes with SRAM read data,
// counts mismatches (saturating) and captures the first failing address/syndrome.
module bist_resp_cmp
   import bist_pkg::*;
#(
   parameter int unsigned ADDR_W    = BIST_ADDR_W,
   parameter int unsigned DATA_W    = BIST_DATA_W,
   parameter int unsigned RD_LAT    = 1,
   parameter int unsigned ERR_CNT_W = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 en_in,
   input  logic                 cmp_en_in,
   input  logic [ADDR_W-1:0]    addr_in,
   input  logic [DATA_W-1:0]    exp_dat_in,
   input  logic [DATA_W-1:0]    ram_dat_in,
   input  logic                 done_in,
   output logic                 busy_out,
   output logic                 done_out,
   output logic                 pass_out,
   output logic                 fail_out,
   output logic [ERR_CNT_W-1:0] err_cnt_out,
   output logic [ADDR_W-1:0]    first_fail_addr_out,
   output logic [DATA_W-1:0]    first_fail_syn_out
);

   typedef struct packed {
      logic              valid;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] exp;
   } entry_t;

   localparam int unsigned DrainW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

   bist_state_e          state_q;
   logic [DrainW-1:0]    drain_cnt_q;
   logic [ERR_CNT_W-1:0] err_cnt_q;
   logic                 fail_q;
   logic [ADDR_W-1:0]    ff_addr_q;
   logic [DATA_W-1:0]    ff_syn_q;

   entry_t            dl_in;
   entry_t            dl_out;
   logic              dl_flush;
   logic              run_or_drain;
   logic [DATA_W-1:0] syn;
   logic              mismatch;

   always_comb begin
      run_or_drain = (state_q == StRun) || (state_q == StDrain);
      dl_in.valid  = cmp_en_in && (state_q == StRun);
      dl_in.addr   = addr_in;
      dl_in.exp    = exp_dat_in;
      // Flush on session start and on abort so partial sweeps never leak across.
      dl_flush     = rst || ((state_q == StIdle) && en_in) || (run_or_drain && !en_in);
      syn          = dl_out.exp ^ ram_dat_in;
      mismatch     = run_or_drain && en_in && dl_out.valid && (syn != '0);
   end

   bist_delay_line #(
      .RD_LAT  (RD_LAT),
      .entry_t (entry_t)
   ) u_delay_line (
      .clk   (clk),
      .flush (dl_flush),
      .d_in  (dl_in),
      .d_out (dl_out)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= StIdle;
         drain_cnt_q <= '0;
         err_cnt_q   <= '0;
         fail_q      <= 1'b0;
         ff_addr_q   <= '0;
         ff_syn_q    <= '0;
      end else begin
         if (mismatch) begin
            if (err_cnt_q != '1) begin
               err_cnt_q <= err_cnt_q + ERR_CNT_W'(1);
            end
            fail_q <= 1'b1;
            if (!fail_q) begin
               ff_addr_q <= dl_out.addr;
               ff_syn_q  <= syn;
            end
         end
         unique case (state_q)
            StIdle: begin
               if (en_in) begin
                  state_q   <= StRun;
                  err_cnt_q <= '0;
                  fail_q    <= 1'b0;
                  ff_addr_q <= '0;
                  ff_syn_q  <= '0;
               end
            end
            StRun: begin
               if (!en_in) begin
                  state_q <= StIdle;
               end else if (done_in) begin
                  state_q     <= StDrain;
                  drain_cnt_q <= '0;
               end
            end
            StDrain: begin
               if (!en_in) begin
                  state_q <= StIdle;
               end else if (drain_cnt_q == DrainW'(RD_LAT - 1)) begin
                  state_q <= StDone;
               end else begin
                  drain_cnt_q <= drain_cnt_q + DrainW'(1);
               end
            end
            StDone: begin
               if (!en_in) begin
                  state_q <= StIdle;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign busy_out            = run_or_drain;
   assign done_out            = (state_q == StDone);
   assign pass_out            = (state_q == StDone) && (err_cnt_q == '0);
   assign fail_out            = fail_q;
   assign err_cnt_out         = err_cnt_q;
   assign first_fail_addr_out = ff_addr_q;
   assign first_fail_syn_out  = ff_syn_q;

endmodule

// File: doc/bist_resp_cmp.md
# bist_resp_cmp

BIST response comparator for the 256x4 SRAM self-test, directly downstream of the `blanket_0` pattern generator. It consumes the generator's read-compare strobe, address and expected data, and aligns them with SRAM read data across a fixed read latency. It compares the two and accumulates a saturating error count, the first failing address and its syndrome. It reports done, pass and fail to the BIST top.

## Interface
- `ADDR_W`, default 8: SRAM address width (256 words).
- `DATA_W`, default 4: SRAM data width.
- `RD_LAT`, default 1: SRAM read latency in cycles, address to `ram_dat_in`; legal range 1..4.
- `ERR_CNT_W`, default 8: error counter width.

Ports:
- `clk`  in  1  single clock; all logic rising-edge.
- `rst`  in  1  synchronous, active-high reset.
- `en_in`  in  1  test session enable; level-sensitive.
- `cmp_en_in`  in  1  compare strobe: a read is issued this cycle at `addr_in` and expects `exp_dat_in`.
- `addr_in`  in  ADDR_W  read address from the generator.
- `exp_dat_in`  in  DATA_W  expected read data.
- `ram_dat_in`  in  DATA_W  SRAM read data port.
- `done_in`  in  1  generator end of sweep (`rst_done`); single-cycle pulse.
- `busy_out`  out  1  state is RUN or DRAIN.
- `done_out`  out  1  state is DONE.
- `pass_out`  out  1  `done_out` and error count == 0.
- `fail_out`  out  1  sticky: at least one mismatch this session.
- `err_cnt_out`  out  ERR_CNT_W  saturating mismatch count.
- `first_fail_addr_out`  out  ADDR_W  address of the first mismatch.
- `first_fail_syn_out`  out  DATA_W  `exp ^ ram` of the first mismatch.

## Operation
- FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE: waits for `en_in`=1. When it arrives, the block goes to RUN and clears count, fail, first-fail registers and the pipeline. Results from the previous session stay readable in IDLE until that happens.
- RUN:
  - Each cycle, `{cmp_en_in, addr_in, exp_dat_in}` enters an RD_LAT-deep delay line.
  - When the delay-line output valid is 1, `ram_dat_in` is compared against the delayed expected data.
  - A mismatch increments the count, saturating at 2^ERR_CNT_W-1, and sets `fail_out`.
  - On the first mismatch only, the delayed address and the syndrome are captured.
- `done_in`=1 in RUN moves to DRAIN. A `cmp_en_in` in the same cycle is still accepted and compared.
- DRAIN: `cmp_en_in` is ignored. A counter runs RD_LAT cycles so in-flight compares retire, then the block goes to DONE.
- DONE: outputs hold. `en_in`=0 returns to IDLE with results kept.
- Abort: `en_in`=0 in RUN or DRAIN returns to IDLE and flushes the pipeline. `done_out` is never asserted for an aborted session; count, fail and first-fail hold their partial values.
- `done_in` outside RUN is ignored. `cmp_en_in` outside RUN is ignored.
- Compare is a full-width XOR; any nonzero bit is a mismatch. X on `ram_dat_in` is not handled specially.

## Timing
- Reset: state IDLE, all outputs 0, delay line valid bits 0. Reset mid-session has the same effect and discards results.
- Compare latency: a strobe at cycle t samples `ram_dat_in` at t+RD_LAT. `err_cnt_out`, `fail_out` and the first-fail outputs update at the edge ending cycle t+RD_LAT, visible in cycle t+RD_LAT+1.
- `done_in` at cycle t: `busy_out`=1 through t+RD_LAT. `done_out` and `pass_out` are 1 from t+RD_LAT+1, together with the final compare result.
- IDLE to RUN: `en_in` sampled at cycle t gives `busy_out`=1 at t+1. A strobe is accepted from t+1.
- All outputs are registered or decoded from the state register; no input-to-output combinational path.

## Structure
- Shared package `bist_pkg`:
  - state enum (IDLE/RUN/DRAIN/DONE);
  - `BIST_ADDR_W`=8 and `BIST_DATA_W`=4;
  - the compare-entry struct `{valid, addr, exp}`.
- Sub-module `bist_delay_line`: parameterised RD_LAT-deep shift register of the compare-entry struct, with synchronous flush.

## Test plan
- Reset: hold `rst`=1 for 2 cycles mid-RUN with 5 prior mismatches. Required: all outputs 0 and IDLE next cycle.
- Clean sweep, RD_LAT=1: strobes on addr 0x00..0xFF, exp 4'hA, SRAM returns 4'hA; `done_in` with addr 0xFF. Required: `done_out`=`pass_out`=1 exactly 2 cycles after `done_in`, `err_cnt_out`=0, `fail_out`=0.
- Single fault: SRAM returns 4'h8 at addr 0x3C, exp 4'hA. Required:
  - `fail_out`=1 two cycles after the 0x3C strobe;
  - `err_cnt_out`=1, `first_fail_addr_out`=0x3C, `first_fail_syn_out`=4'h2;
  - `pass_out`=0 at done.
- Multiple faults, RD_LAT=2: mismatches at 0x10, 0x20, 0xFF, with the 0xFF strobe coincident with `done_in`. Required: `err_cnt_out`=3, first address 0x10, `done_out` 3 cycles after `done_in`.
- Saturation, ERR_CNT_W=4: 256 mismatches. Required: `err_cnt_out`=4'hF and holds.
- Abort: `en_in`=0 at addr 0x64 after 1 mismatch. Required: IDLE next cycle, `done_out` never 1, `err_cnt_out`=1 held; re-enable clears to 0.
